// File: rtl/bt_air_channel_n.sv
// Over-the-air channel model linking NDEV baseband devices on a shared clk_6M.
// Ports: clk_6M/rst (sync, active-high); per-device tx enable, bit and hop
//   channel in; per-device rx bit/valid/collision out; regi_* config; cnt_sel
//   selects which device's bits/errs/colls counters drive cnt_*; cnt_clr zeroes them.
module bt_air_channel_n #(
    parameter int          NDEV     = 4,
    parameter int          DELAY    = 2,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                clk_6M,
    input  logic                rst,
    input  logic [NDEV-1:0]     dev_txen,
    input  logic [NDEV-1:0]     dev_txbit,
    input  logic [7*NDEV-1:0]   dev_fk,
    input  logic                regi_chan_en,
    input  logic                regi_err_en,
    input  logic [15:0]         regi_ber_thresh,
    input  logic [3:0]          cnt_sel,
    input  logic                cnt_clr,
    output logic [NDEV-1:0]     dev_rxbit,
    output logic [NDEV-1:0]     dev_rxvalid,
    output logic [NDEV-1:0]     dev_collision,
    output logic [15:0]         cnt_bits,
    output logic [15:0]         cnt_errs,
    output logic [15:0]         cnt_colls
);

    logic [15:0]     lfsr_q, lfsr_d;
    logic [NDEV-1:0] bit_d, vld_d, col_d, err_d;
    logic [NDEV-1:0] bit_q [DELAY];
    logic [NDEV-1:0] vld_q [DELAY];
    logic [NDEV-1:0] col_q [DELAY];
    logic [NDEV-1:0] err_q [DELAY];
    logic [15:0]     bits_q  [NDEV];
    logic [15:0]     errs_q  [NDEV];
    logic [15:0]     colls_q [NDEV];
    logic [NDEV-1:0] match;
    logic [15:0]     rot;

    // Fibonacci LFSR, taps 16,14,13,11; only runs while errors are enabled.
    always_comb begin
        lfsr_d = lfsr_q;
        if (regi_err_en)
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Per-receiver resolution of matching transmitters.
    always_comb begin
        bit_d = {NDEV{IDLE_BIT}};
        vld_d = '0;
        col_d = '0;
        err_d = '0;
        match = '0;
        rot   = '0;
        for (int i = 0; i < NDEV; i++) begin
            match = '0;
            for (int j = 0; j < NDEV; j++) begin
                if (j != i && dev_txen[j] && !dev_txen[i] &&
                    (!regi_chan_en || dev_fk[7*j +: 7] == dev_fk[7*i +: 7]))
                    match[j] = 1'b1;
            end
            // Each receiver sees a different rotation so errors decorrelate.
            rot = (lfsr_q << i) | (lfsr_q >> (16 - i));
            if ($onehot(match)) begin
                vld_d[i] = 1'b1;
                err_d[i] = regi_err_en && (rot < regi_ber_thresh);
                bit_d[i] = (|(match & dev_txbit)) ^ err_d[i];
            end else if (match != '0) begin
                col_d[i] = 1'b1;
            end
        end
    end

    // Air-delay pipeline: stage 0 registers the resolution, the rest just delay it.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            lfsr_q <= SEED;
            for (int s = 0; s < DELAY; s++) begin
                bit_q[s] <= {NDEV{IDLE_BIT}};
                vld_q[s] <= '0;
                col_q[s] <= '0;
                err_q[s] <= '0;
            end
        end else begin
            lfsr_q   <= lfsr_d;
            bit_q[0] <= bit_d;
            vld_q[0] <= vld_d;
            col_q[0] <= col_d;
            err_q[0] <= err_d;
            for (int s = 1; s < DELAY; s++) begin
                bit_q[s] <= bit_q[s-1];
                vld_q[s] <= vld_q[s-1];
                col_q[s] <= col_q[s-1];
                err_q[s] <= err_q[s-1];
            end
        end
    end

    assign dev_rxbit     = bit_q[DELAY-1];
    assign dev_rxvalid   = vld_q[DELAY-1];
    assign dev_collision = col_q[DELAY-1];

    // Saturating statistics taken from the output stage; clear beats increment.
    always_ff @(posedge clk_6M) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < NDEV; i++) begin
                bits_q[i]  <= '0;
                errs_q[i]  <= '0;
                colls_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NDEV; i++) begin
                if (vld_q[DELAY-1][i] && bits_q[i] != 16'hFFFF)
                    bits_q[i] <= bits_q[i] + 16'd1;
                if (err_q[DELAY-1][i] && errs_q[i] != 16'hFFFF)
                    errs_q[i] <= errs_q[i] + 16'd1;
                if (col_q[DELAY-1][i] && colls_q[i] != 16'hFFFF)
                    colls_q[i] <= colls_q[i] + 16'd1;
            end
        end
    end

    // Unpopulated selections read as zero.
    always_comb begin
        cnt_bits  = '0;
        cnt_errs  = '0;
        cnt_colls = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (cnt_sel == 4'(i)) begin
                cnt_bits  = bits_q[i];
                cnt_errs  = errs_q[i];
                cnt_colls = colls_q[i];
            end
        end
    end

endmodule

// File: tb/tb_bt_air_channel_n.sv
// Self-checking bench for bt_air_channel_n: directed link/collision/error/
// saturation/reset scenarios plus random traffic against a queue-based model.
module tb_bt_air_channel_n;

    localparam int          NDEV  = 4;
    localparam int          DELAY = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic        IDLE  = 1'b0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NDEV-1:0]   dev_txen = '0;
    logic [NDEV-1:0]   dev_txbit = '0;
    logic [7*NDEV-1:0] dev_fk = '0;
    logic              regi_chan_en = 1'b1;
    logic              regi_err_en = 1'b0;
    logic [15:0]       regi_ber_thresh = '0;
    logic [3:0]        cnt_sel = '0;
    logic              cnt_clr = 1'b0;
    logic [NDEV-1:0]   dev_rxbit, dev_rxvalid, dev_collision;
    logic [15:0]       cnt_bits, cnt_errs, cnt_colls;

    always #5 clk = ~clk;

    bt_air_channel_n #(
        .NDEV(NDEV), .DELAY(DELAY), .SEED(SEED), .IDLE_BIT(IDLE)
    ) dut (
        .clk_6M(clk), .rst(rst), .dev_txen(dev_txen), .dev_txbit(dev_txbit),
        .dev_fk(dev_fk), .regi_chan_en(regi_chan_en),
        .regi_err_en(regi_err_en), .regi_ber_thresh(regi_ber_thresh),
        .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .dev_rxbit(dev_rxbit),
        .dev_rxvalid(dev_rxvalid), .dev_collision(dev_collision),
        .cnt_bits(cnt_bits), .cnt_errs(cnt_errs), .cnt_colls(cnt_colls)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [NDEV-1:0] b;
        logic [NDEV-1:0] v;
        logic [NDEV-1:0] c;
        logic [NDEV-1:0] e;
    } ent_t;

    ent_t        pipe[$];
    logic [15:0] m_lfsr;
    int          m_bits[NDEV];
    int          m_errs[NDEV];
    int          m_colls[NDEV];
    bit          live = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        logic [31:0] w;
        w = {v, v} << n;
        return w[31:16];
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | 16'(fb << 15);
    endfunction

    function automatic ent_t resolve();
        ent_t r;
        int m, who;
        r.b = {NDEV{IDLE}};
        r.v = '0;
        r.c = '0;
        r.e = '0;
        for (int i = 0; i < NDEV; i++) begin
            m = 0;
            who = -1;
            if (!dev_txen[i]) begin
                for (int j = 0; j < NDEV; j++) begin
                    if (j == i || !dev_txen[j]) continue;
                    if (regi_chan_en && dev_fk[7*j +: 7] != dev_fk[7*i +: 7])
                        continue;
                    m++;
                    who = j;
                end
            end
            if (m == 1) begin
                r.v[i] = 1'b1;
                r.e[i] = regi_err_en && (rotl(m_lfsr, i) < regi_ber_thresh);
                r.b[i] = r.e[i] ? ~dev_txbit[who] : dev_txbit[who];
            end else if (m >= 2) begin
                r.c[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference model and per-cycle compare.
    always @(posedge clk) begin
        ent_t o, e;
        int xb, xe, xc;
        if (rst) begin
            pipe.delete();
            o.b = {NDEV{IDLE}};
            o.v = '0;
            o.c = '0;
            o.e = '0;
            repeat (DELAY) pipe.push_back(o);
            m_lfsr = SEED;
            for (int d = 0; d < NDEV; d++) begin
                m_bits[d] = 0;
                m_errs[d] = 0;
                m_colls[d] = 0;
            end
            live = 1'b1;
        end else if (live) begin
            o = pipe[0];
            for (int d = 0; d < NDEV; d++) begin
                if (cnt_clr) begin
                    m_bits[d] = 0;
                    m_errs[d] = 0;
                    m_colls[d] = 0;
                end else begin
                    if (o.v[d] && m_bits[d] < 65535) m_bits[d]++;
                    if (o.e[d] && m_errs[d] < 65535) m_errs[d]++;
                    if (o.c[d] && m_colls[d] < 65535) m_colls[d]++;
                end
            end
            e = resolve();
            pipe.push_back(e);
            void'(pipe.pop_front());
            if (regi_err_en) m_lfsr = lfsr_step(m_lfsr);
        end
        #1;
        if (live) begin
            o = pipe[0];
            xb = 0; xe = 0; xc = 0;
            if (int'(cnt_sel) < NDEV) begin
                xb = m_bits[cnt_sel];
                xe = m_errs[cnt_sel];
                xc = m_colls[cnt_sel];
            end
            tests++;
            if (dev_rxbit !== o.b || dev_rxvalid !== o.v ||
                dev_collision !== o.c || cnt_bits !== 16'(xb) ||
                cnt_errs !== 16'(xe) || cnt_colls !== 16'(xc)) begin
                fails++;
                if (fails < 30)
                    $display("FAIL cycle t=%0t: rx=%h/%h/%h cnt=%h/%h/%h expected rx=%h/%h/%h cnt=%h/%h/%h",
                             $time, dev_rxbit, dev_rxvalid, dev_collision,
                             cnt_bits, cnt_errs, cnt_colls, o.b, o.v, o.c,
                             16'(xb), 16'(xe), 16'(xc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
    endtask

    task automatic set_fk(input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] c, input logic [6:0] d);
        dev_fk = {d, c, b, a};
    endtask

    task automatic read_sel(input logic [3:0] s);
        cnt_sel = s;
        #1;
    endtask

    // Dev0 sends 1011; optionally pins the receive stream of dev1.
    task automatic send1011(input bit pin);
        logic [3:0] p;
        p = 4'b1011;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                dev_txen  = 4'b0001;
                dev_txbit = {3'b000, p[3-k]};
            end else begin
                dev_txen = '0;
            end
            tick(1);
            if (pin && k >= 3) begin
                chk("link_rxbit1", dev_rxbit[1], p[6-k]);
                chk("link_rxvalid1", dev_rxvalid[1], 1'b1);
                chk("link_rxvalid0", dev_rxvalid[0], 1'b0);
            end
        end
        tick(DELAY + 2);
    endtask

    initial begin
        int n;
        tick(2);
        chk("rst_rxvalid", dev_rxvalid, '0);
        chk("rst_coll", dev_collision, '0);
        chk("rst_rxbit", dev_rxbit, {NDEV{IDLE}});
        chk("rst_cnt_bits", cnt_bits, 0);
        rst = 1'b0;

        // Single link on matching channel.
        set_fk(7'd12, 7'd12, 7'd20, 7'd30);
        send1011(1'b1);
        read_sel(4'd1);
        chk("link_cnt_bits", cnt_bits, 16'd4);
        chk("link_cnt_errs", cnt_errs, 16'd0);

        // Mismatched hop channel, then broadcast.
        clr();
        set_fk(7'd12, 7'd13, 7'd20, 7'd30);
        send1011(1'b0);
        read_sel(4'd1);
        chk("fkmis_cnt_bits", cnt_bits, 16'd0);
        chk("fkmis_cnt_colls", cnt_colls, 16'd0);
        regi_chan_en = 1'b0;
        send1011(1'b1);
        read_sel(4'd1);
        chk("bcast_cnt_bits1", cnt_bits, 16'd4);
        read_sel(4'd3);
        chk("bcast_cnt_bits3", cnt_bits, 16'd4);
        read_sel(4'd9);
        chk("sel_oob", cnt_bits, 16'd0);
        regi_chan_en = 1'b1;

        // Collision: devs 0 and 1 on fk 5, dev2 listens.
        clr();
        set_fk(7'd5, 7'd5, 7'd5, 7'd9);
        dev_txen = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            dev_txbit = 4'($urandom_range(0, 15));
            tick(1);
        end
        dev_txen = '0;
        tick(DELAY + 2);
        read_sel(4'd2);
        chk("coll_cnt_colls", cnt_colls, 16'd10);
        chk("coll_cnt_bits", cnt_bits, 16'd0);

        // Error injection at both threshold extremes.
        set_fk(7'd12, 7'd12, 7'd20, 7'd30);
        regi_err_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            regi_ber_thresh = (t == 0) ? 16'h0000 : 16'hFFFF;
            clr();
            dev_txen = 4'b0001;
            for (int k = 0; k < 1000; k++) begin
                dev_txbit = {3'b000, 1'($urandom_range(0, 1))};
                tick(1);
            end
            dev_txen = '0;
            tick(DELAY + 2);
            read_sel(4'd1);
            chk("err_cnt_bits", cnt_bits, 16'd1000);
            if (t == 0)
                chk("err_thresh0", cnt_errs, 16'd0);
            else
                chk("err_threshmax_range", 32'(cnt_errs >= 16'd996 &&
                                                cnt_errs <= 16'd1000), 32'd1);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            dev_txen  = 4'($urandom_range(0, 15));
            dev_txbit = 4'($urandom_range(0, 15));
            set_fk(7'(3 + $urandom_range(0, 1)), 7'(3 + $urandom_range(0, 1)),
                   7'(3 + $urandom_range(0, 1)), 7'(3 + $urandom_range(0, 1)));
            regi_chan_en = ($urandom_range(0, 9) != 0);
            if (k % 50 == 0) begin
                regi_err_en = 1'($urandom_range(0, 1));
                regi_ber_thresh = 16'($urandom_range(0, 65535));
            end
            cnt_sel = 4'($urandom_range(0, 15));
            cnt_clr = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        cnt_clr = 1'b0;
        dev_txen = '0;
        regi_chan_en = 1'b1;
        regi_err_en = 1'b0;
        tick(DELAY + 2);

        // Saturation of the bit counter.
        set_fk(7'd12, 7'd12, 7'd20, 7'd30);
        clr();
        dev_txen = 4'b0001;
        dev_txbit = 4'b0001;
        n = 65534;
        tick(n);
        dev_txen = '0;
        tick(DELAY + 2);
        read_sel(4'd1);
        chk("sat_preload", cnt_bits, 16'hFFFE);
        dev_txen = 4'b0001;
        tick(5);
        dev_txen = '0;
        tick(DELAY + 2);
        chk("sat_hold", cnt_bits, 16'hFFFF);
        dev_txen = 4'b0001;
        tick(DELAY + 2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_wins", cnt_bits, 16'd0);
        tick(1);
        chk("after_clr_inc", cnt_bits, 16'd1);
        dev_txen = '0;
        tick(DELAY + 2);

        // Reset mid-stream with errors enabled.
        regi_err_en = 1'b1;
        regi_ber_thresh = 16'h8000;
        dev_txen = 4'b0001;
        dev_txbit = 4'b0001;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_rxvalid", dev_rxvalid, '0);
        chk("mrst_coll", dev_collision, '0);
        chk("mrst_rxbit", dev_rxbit, {NDEV{IDLE}});
        for (int k = 1; k <= DELAY; k++) begin
            tick(1);
            chk("mrst_valid_lat", dev_rxvalid[1], (k == DELAY));
        end
        chk("mrst_seed_err_bit", dev_rxbit[1], 1'b0);
        tick(10);
        dev_txen = '0;
        tick(DELAY + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
